hazard_scoreboard: RTL

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

---
 rtl/hazard_scoreboard_if.sv | 33 +++
 rtl/hazard_scoreboard.sv | 106 ++++++++++
 2 files changed

// File: rtl/hazard_scoreboard_if.sv
// Decode/memory-side bundle for the load hazard scoreboard.
// Pure wiring: no latency of its own.
// The master drives issue requests and mem_ack and honours stall; the slave drives status.
interface hazard_scoreboard_if;
  logic       issue_valid;
  logic       issue_is_load;
  logic       issue_writes;
  logic [3:0] issue_dest;
  logic [3:0] src_a;
  logic [3:0] src_b;
  logic       src_a_used;
  logic       src_b_used;
  logic       mem_ack;
  logic       stall;
  logic [15:0] pending;
  logic       wb_valid;
  logic [3:0] wb_dest;
  logic [1:0] load_count;
  logic       ack_err;
  logic [7:0] stall_cycles;

  modport master (
    output issue_valid, issue_is_load, issue_writes, issue_dest,
    output src_a, src_b, src_a_used, src_b_used, mem_ack,
    input  stall, pending, wb_valid, wb_dest, load_count, ack_err, stall_cycles
  );

  modport slave (
    input  issue_valid, issue_is_load, issue_writes, issue_dest,
    input  src_a, src_b, src_a_used, src_b_used, mem_ack,
    output stall, pending, wb_valid, wb_dest, load_count, ack_err, stall_cycles
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Tracks up to two outstanding loads and stalls decode on RAW/WAW hazards or a full load queue.
// stall is combinational; pushes/pops land on the next edge, wb_valid pulses the cycle after a pop.
// Backpressure: stall holds decode; a full queue still accepts a load in the same cycle as mem_ack.
module hazard_scoreboard (
  input logic clk,
  input logic rst,
  hazard_scoreboard_if.slave sb
);

  // Two-entry in-order queue of load destinations; head is the oldest load.
  logic [3:0]  head_q;
  logic [3:0]  tail_q;
  logic [1:0]  count_q;
  logic [15:0] pend;
  logic        raw;
  logic        waw;
  logic        full;
  logic        stall;
  logic        push;
  logic        pop;
  logic        spurious;
  logic        wb_valid_q;
  logic [3:0]  wb_dest_q;
  logic        ack_err_q;
  logic [7:0]  stall_cycles_q;

  // Pending mask decoded from the queue registers only, so a popped register stays pending for the pop cycle.
  always_comb begin
    pend = '0;
    if (count_q != 2'd0) pend[head_q] = 1'b1;
    if (count_q == 2'd2) pend[tail_q] = 1'b1;
  end

  // Hazard detection and the handshake qualifiers derived from it.
  always_comb begin
    raw      = (sb.src_a_used & pend[sb.src_a]) | (sb.src_b_used & pend[sb.src_b]);
    waw      = sb.issue_writes & pend[sb.issue_dest];
    full     = sb.issue_is_load & (count_q == 2'd2) & ~sb.mem_ack;
    stall    = sb.issue_valid & (raw | waw | full);
    push     = sb.issue_valid & ~stall & sb.issue_is_load;
    pop      = sb.mem_ack & (count_q != 2'd0);
    spurious = sb.mem_ack & (count_q == 2'd0);
  end

  // Queue update; a full queue can only push when it also pops, so count never exceeds two.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count_q == 2'd0) head_q <= sb.issue_dest;
          else                 tail_q <= sb.issue_dest;
          count_q <= count_q + 2'd1;
        end
        2'b01: begin
          head_q  <= tail_q;
          count_q <= count_q - 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd1) begin
            head_q <= sb.issue_dest;
          end else begin
            head_q <= tail_q;
            tail_q <= sb.issue_dest;
          end
        end
        default: ;
      endcase
    end
  end

  // Writeback pulse carrying the register just retired from the head.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_valid_q <= 1'b0;
      wb_dest_q  <= '0;
    end else begin
      wb_valid_q <= pop;
      if (pop) wb_dest_q <= head_q;
    end
  end

  // Sticky error for an acknowledge that arrives with nothing outstanding.
  always_ff @(posedge clk) begin
    if (rst)           ack_err_q <= 1'b0;
    else if (spurious) ack_err_q <= 1'b1;
  end

  // Saturating stall-cycle counter for performance monitoring.
  always_ff @(posedge clk) begin
    if (rst)                                 stall_cycles_q <= '0;
    else if (stall && stall_cycles_q != 8'hFF) stall_cycles_q <= stall_cycles_q + 8'd1;
  end

  assign sb.stall        = stall;
  assign sb.pending      = pend;
  assign sb.wb_valid     = wb_valid_q;
  assign sb.wb_dest      = wb_dest_q;
  assign sb.load_count   = count_q;
  assign sb.ack_err      = ack_err_q;
  assign sb.stall_cycles = stall_cycles_q;

endmodule
